// File: rtl/ssd_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.
// Frame data is snapshotted once per frame so a changing marquee never tears mid-scan.
module ssd_scan_driver #(
    parameter int SCAN_DIV     = 40000,
    parameter int BLANK_CYCLES = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code0,
    input  logic [3:0] code1,
    input  logic [3:0] code2,
    input  logic [3:0] code3,
    input  logic [3:0] dp_mask,
    input  logic       en,
    output logic [3:0] ssd_ctl,
    output logic [7:0] segs,
    output logic       frame_done
);

    localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] CNT_BLANK = 16'(BLANK_CYCLES);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [3:0]  snap_code [4];
    logic [3:0]  snap_dp;
    logic [3:0]  code_in [4];
    logic        frame_start;

    assign code_in[0]  = code0;
    assign code_in[1]  = code1;
    assign code_in[2]  = code2;
    assign code_in[3]  = code3;
    assign frame_start = en && (idx == 2'd0) && (cnt == 16'd0);

    // Lit segments {a,b,c,d,e,f,g}, active high.
    function automatic logic [6:0] seg_lit(input logic [3:0] c);
        logic [6:0] s;
        s = 7'b0000000;
        case (c)
            4'd0:  s = 7'b1110111;
            4'd1:  s = 7'b1001110;
            4'd2:  s = 7'b1001111;
            4'd3:  s = 7'b1000111;
            4'd4:  s = 7'b1011110;
            4'd5:  s = 7'b0110111;
            4'd6:  s = 7'b0000110;
            4'd7:  s = 7'b0001110;
            4'd8:  s = 7'b1100111;
            4'd9:  s = 7'b0000101;
            4'd10: s = 7'b1011011;
            4'd11: s = 7'b0001111;
            4'd12: s = 7'b0111110;
            4'd13: s = 7'b1111110;
            4'd14: s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 16'd0;
            idx     <= 2'd0;
            snap_dp <= 4'd0;
            for (int i = 0; i < 4; i++) snap_code[i] <= 4'hF;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= 16'd0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (frame_start) begin
                snap_dp <= dp_mask;
                for (int i = 0; i < 4; i++) snap_code[i] <= code_in[i];
            end
        end
    end

    // Outputs use the pre-load snapshot; the slot-0 blank window hides the swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssd_ctl    <= 4'b1111;
            segs       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_start;
            if (!en || (cnt < CNT_BLANK)) begin
                ssd_ctl <= 4'b1111;
                segs    <= 8'hFF;
            end else begin
                ssd_ctl <= ~(4'b1000 >> idx);
                segs    <= ~{seg_lit(snap_code[idx]), snap_dp[idx]};
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a frame-position reference model queues the
// expected registered outputs, a negedge monitor pops and compares them.
module tb_ssd_scan_driver;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code0 = 4'hF, code1 = 4'hF, code2 = 4'hF, code3 = 4'hF;
    logic [3:0] dp_mask = 4'h0;
    logic       en = 1'b0;
    logic [3:0] ssd_ctl;
    logic [7:0] segs;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    ssd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .dp_mask(dp_mask), .en(en),
        .ssd_ctl(ssd_ctl), .segs(segs), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Character glyphs as lit segment letters.
    string glyph [16] = '{"abcefg", "adef", "adefg", "aefg", "acdef", "bcefg", "ef", "def",
                          "abefg", "eg", "acdfg", "defg", "bcdef", "abcdef", "g", ""};

    function automatic logic [7:0] seg_model(input logic [3:0] c, input logic dp);
        logic [7:0] s;
        int b;
        s = 8'hFF;
        for (int i = 0; i < glyph[c].len(); i++) begin
            b = int'(glyph[c][i]) - 97;
            s[7 - b] = 1'b0;
        end
        if (dp) s[0] = 1'b0;
        return s;
    endfunction

    // Reference model: one position counter across the whole frame.
    logic [12:0] exp_q [$];
    int          pos;
    logic [3:0]  m_code [4];
    logic [3:0]  m_dp;

    always @(posedge clk) begin
        logic [3:0] ec;
        logic [7:0] es;
        logic       ef;
        int         d;
        ec = 4'b1111;
        es = 8'hFF;
        ef = 1'b0;
        if (rst) begin
            pos  = 0;
            m_dp = 4'h0;
            for (int i = 0; i < 4; i++) m_code[i] = 4'hF;
        end else if (en) begin
            d = pos / SCAN_DIV;
            if ((pos % SCAN_DIV) >= BLANK_CYCLES) begin
                ec[3 - d] = 1'b0;
                es = seg_model(m_code[d], m_dp[d]);
            end
            if (pos == 0) begin
                ef = 1'b1;
                m_code[0] = code0; m_code[1] = code1;
                m_code[2] = code2; m_code[3] = code3;
                m_dp = dp_mask;
            end
            pos = (pos + 1) % FRAME;
        end
        exp_q.push_back({ec, es, ef});
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got no expected entry, required one per cycle");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (ssd_ctl !== e[12:9]) begin
                errors++;
                $display("FAIL sb_ctl @%0t: got=%b exp=%b", $time, ssd_ctl, e[12:9]);
            end
            checks++;
            if (segs !== e[8:1]) begin
                errors++;
                $display("FAIL sb_segs @%0t: got=%h exp=%h", $time, segs, e[8:1]);
            end
            checks++;
            if (frame_done !== e[0]) begin
                errors++;
                $display("FAIL sb_frame_done @%0t: got=%b exp=%b", $time, frame_done, e[0]);
            end
        end
        checks++;
        if ($countones(~ssd_ctl) > 1) begin
            errors++;
            $display("FAIL one_hot @%0t: got=%b exp=at most one low bit", $time, ssd_ctl);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++; errors++;
            $display("FAIL wait_fd: got no frame_done in %0d cycles, required one", n);
        end
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'(ssd_ctl), 32'hF);
        chk("rst_segs", 32'(segs), 32'hFF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: P, I, t, C
        code0 = 4'd8; code1 = 4'd6; code2 = 4'd11; code3 = 4'd1; dp_mask = 4'h0; en = 1'b1;
        wait_fd(n);
        chk("first_fd_latency", 32'(n), 32'd1);
        repeat (2) @(negedge clk);
        chk("d0_ctl", 32'(ssd_ctl), 32'h7);
        chk("d0_segs_P", 32'(segs), 32'h31);
        repeat (24) @(negedge clk);
        chk("d3_ctl", 32'(ssd_ctl), 32'hE);
        chk("d3_segs_C", 32'(segs), 32'h63);
        wait_fd(n);
        chk("fd_tail", 32'(n), 32'd6);

        // Mid-frame code change must not tear
        repeat (3) @(negedge clk);
        code0 = 4'd2;
        repeat (2) @(negedge clk);
        chk("no_tear_segs", 32'(segs), 32'h31);
        wait_fd(n);
        repeat (2) @(negedge clk);
        chk("new_frame_E", 32'(segs), 32'h61);

        // Blank code with and without dp
        code0 = 4'd15; code1 = 4'd15; code2 = 4'd15; code3 = 4'd15; dp_mask = 4'b0001;
        wait_fd(n);
        chk("fd_period", 32'(n), 32'(FRAME - 2));
        repeat (2) @(negedge clk);
        chk("blank_dp_ctl", 32'(ssd_ctl), 32'h7);
        chk("blank_dp_segs", 32'(segs), 32'hFE);
        repeat (8) @(negedge clk);
        chk("blank_nodp_ctl", 32'(ssd_ctl), 32'hB);
        chk("blank_nodp_segs", 32'(segs), 32'hFF);

        // Enable dropped at idx=2, cnt=5 for 10 cycles
        code2 = 4'd13;
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_ctl", 32'(ssd_ctl), 32'hF);
        chk("en_off_segs", 32'(segs), 32'hFF);
        repeat (9) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("resume_ctl", 32'(ssd_ctl), 32'hD);
        chk("resume_fd", 32'(frame_done), 32'h0);
        wait_fd(n);
        chk("resume_to_fd", 32'(n), 32'd11);

        // Asynchronous reset mid-slot
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctl", 32'(ssd_ctl), 32'hF);
        chk("async_rst_segs", 32'(segs), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fd", 32'(frame_done), 32'h1);

        // Sweep every code through digit 1
        for (int c = 0; c < 16; c++) begin
            code0 = 4'($urandom); code1 = 4'(c); code2 = 4'($urandom); code3 = 4'($urandom);
            dp_mask = 4'($urandom);
            wait_fd(n);
            repeat (16) @(negedge clk);
        end

        // Random traffic with enable gaps
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                code0 = 4'($urandom); code1 = 4'($urandom);
                code2 = 4'($urandom); code3 = 4'($urandom);
                dp_mask = 4'($urandom);
            end
        end
        en = 1'b1;
        repeat (FRAME + 4) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 40000, meaning clock cycles per digit slot; legal range 4..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 400, meaning the anti-ghost blank cycles at the start of each slot; legal only if BLANK_CYCLES < SCAN_DIV.
REQ-003 SHALL have port clk, input, 1, the single global clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports code0..code3, input, 4 each, character codes from the marquee shift register; code0 is the leftmost digit.
REQ-006 SHALL have port dp_mask, input, 4, decimal-point request; bit i applies to code i.
REQ-007 SHALL have port en, input, 1, scan enable.
REQ-008 SHALL have port ssd_ctl, output, 4, active-low one-hot digit enable; code i drives ssd_ctl[3-i].
REQ-009 SHALL have port segs, output, 8, active-low segments in the order {a,b,c,d,e,f,g,dp}, MSB = a.
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse each time a new frame snapshot is taken.

Function
REQ-011 SHALL keep a slot counter cnt that runs 0..SCAN_DIV-1 while en=1, wraps to 0 after SCAN_DIV-1, and holds its value while en=0.
REQ-012 SHALL keep a digit index idx (2 bits) that advances 0->1->2->3->0 on the cycle cnt wraps; it holds while en=0.
REQ-013 SHALL load code0..code3 and dp_mask into a snapshot on every cycle with en=1, idx=0 and cnt=0; all displayed data SHALL come from this snapshot, so there is no mid-frame tearing.
REQ-014 SHALL assert frame_done for exactly the snapshot cycles in REQ-013.
REQ-015 SHALL decode characters as follows (lit segments): 0 A abcefg; 1 C adef; 2 E adefg; 3 F aefg; 4 G acdef; 5 H bcefg; 6 I ef; 7 L def; 8 P abefg; 9 r eg; 10 S acdfg; 11 t defg; 12 U bcdef; 13 O abcdef; 14 - g; 15 blank (none lit).
REQ-016 SHALL light dp for the active digit when its snapshot dp_mask bit is 1, regardless of code, including code 15.
REQ-017 SHALL drive ssd_ctl=4'b1111 and segs=8'hFF while cnt < BLANK_CYCLES.
REQ-018 SHALL otherwise drive ssd_ctl low only at bit 3-idx, with segs set to the decoded snapshot character idx.
REQ-019 SHALL drive ssd_ctl=4'b1111 and segs=8'hFF while en=0.
REQ-020 SHALL register ssd_ctl, segs and frame_done; each output at cycle t+1 reflects the cnt, idx, snapshot and en of cycle t.
REQ-021 SHALL, when en rises, resume from the held cnt/idx with no re-snapshot unless idx=0 and cnt=0.
REQ-022 SHALL never assert two ssd_ctl bits low in the same cycle.

Reset
REQ-023 SHALL, while rst=1, force cnt=0, idx=0, snapshot codes=15, snapshot dp=0, ssd_ctl=4'b1111, segs=8'hFF and frame_done=0, independent of clk.
REQ-024 SHALL, when rst is asserted mid-slot, abort the slot immediately; after release, the first en=1 cycle takes a snapshot (frame_done pulse) and starts slot 0.

Verification
REQ-025 SHALL cover: SCAN_DIV=8, BLANK_CYCLES=2, codes {8,6,11,1}, dp_mask=0, en=1 -> digit 0 shows ssd_ctl=4'b0111, segs=8'h31 (P) for 6 cycles after 2 blank cycles; digit 3 shows 4'b1110, 8'h63 (C); frame_done pulses every 32 cycles.
REQ-026 SHALL cover: code0 changing 8->2 mid-frame -> display unchanged until the next frame_done; then digit 0 shows segs=8'h61 (E).
REQ-027 SHALL cover: code 15 with dp_mask=4'b0001 -> digit 0 segs=8'hFE; code 15 with dp=0 -> 8'hFF while ssd_ctl is still active.
REQ-028 SHALL cover: en dropped at idx=2, cnt=5 for 10 cycles -> outputs 4'b1111/8'hFF; cnt and idx held; resume at idx=2, cnt=5 with no frame_done.
REQ-029 SHALL cover: rst pulsed asynchronously between clk edges mid-slot -> outputs go to 4'b1111/8'hFF before the next edge; after release, frame_done on the first en=1 cycle.
REQ-030 SHALL cover: all 16 codes swept through digit 1 -> segs match REQ-015 exactly, and one-hot ssd_ctl is checked every cycle of the run.
